// File: rtl/seq_gen_tx_pkg.sv
// Shared definitions for the serial test-pattern transmitter: FSM state
// encodings, default build parameters and a counter-width helper.
package seq_gen_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_REP_W = 4;
    localparam int DEF_GAP   = 2;

    // Bits needed to hold a down-counter starting at n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_gen_shreg.sv
// Load/shift register for the transmitter: holds the bits still to be sent
// below the one currently on the line, plus a bit counter with a 'last' flag.
module seq_gen_shreg
    import seq_gen_tx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-2:0] load_data,
    output logic             next_bit,
    output logic             last
);

    localparam int CNT_W = cnt_width(WIDTH);

    logic [WIDTH-2:0] sr;
    logic [CNT_W-1:0] bit_cnt;

    // The MSB goes straight to the line on load, so only the remaining bits are kept here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            sr      <= load_data;
            bit_cnt <= CNT_W'(WIDTH - 1);
        end else if (shift) begin
            sr      <= sr << 1;
            bit_cnt <= bit_cnt - 1'b1;
        end
    end

    assign next_bit = sr[WIDTH-2];
    assign last     = (bit_cnt == '0);

endmodule

// File: rtl/seq_gen_tx.sv
// Serial test-pattern transmitter: sends a captured pattern MSB-first,
// reps+1 times with GAP idle cycles between copies, then pulses done.
module seq_gen_tx
    import seq_gen_tx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int REP_W = DEF_REP_W,
    parameter int GAP   = DEF_GAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [REP_W-1:0] reps,
    output logic             dataout,
    output logic             busy,
    output logic             done
);

    localparam int GAP_W = cnt_width(GAP);
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             dout_d, busy_d, done_d;

    logic             sr_load, sr_shift, sr_next_bit, sr_last;
    logic [WIDTH-2:0] sr_data;

    seq_gen_shreg #(
        .WIDTH(WIDTH)
    ) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .load     (sr_load),
        .shift    (sr_shift),
        .load_data(sr_data),
        .next_bit (sr_next_bit),
        .last     (sr_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            dataout <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            dataout <= dout_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Every value is computed one cycle ahead so the outputs come straight from flops.
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        rep_d    = rep_q;
        gap_d    = gap_q;
        dout_d   = 1'b0;
        busy_d   = busy;
        done_d   = 1'b0;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        sr_data  = pat_q[WIDTH-2:0];

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    pat_d   = pattern;
                    rep_d   = reps;
                    sr_load = 1'b1;
                    sr_data = pattern[WIDTH-2:0];
                    dout_d  = pattern[WIDTH-1];
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!sr_last) begin
                    sr_shift = 1'b1;
                    dout_d   = sr_next_bit;
                end else if (rep_q == '0) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (GAP == 0) begin
                    sr_load = 1'b1;
                    dout_d  = pat_q[WIDTH-1];
                    rep_d   = rep_q - 1'b1;
                end else begin
                    gap_d   = GAP_LAST;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    sr_load = 1'b1;
                    dout_d  = pat_q[WIDTH-1];
                    rep_d   = rep_q - 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_seq_gen_tx.sv
// Scoreboard bench for seq_gen_tx: a GAP=2 and a GAP=0 instance, each with a
// queue of expected {dataout,busy,done} per cycle built from the transmit rules.
module tb_seq_gen_tx;

    localparam int W     = 8;
    localparam int RW    = 4;
    localparam int GAP_A = 2;
    localparam int GAP_B = 0;

    logic          clk, rst, start_a, start_b;
    logic [W-1:0]  pattern;
    logic [RW-1:0] reps;
    logic          dout_a, busy_a, done_a;
    logic          dout_b, busy_b, done_b;

    logic [2:0]    q_a[$];
    logic [2:0]    q_b[$];
    int            vectors_applied = 0;
    int            miscompares     = 0;

    seq_gen_tx #(.WIDTH(W), .REP_W(RW), .GAP(GAP_A)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .pattern(pattern), .reps(reps),
        .dataout(dout_a), .busy(busy_a), .done(done_a)
    );

    seq_gen_tx #(.WIDTH(W), .REP_W(RW), .GAP(GAP_B)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .pattern(pattern), .reps(reps),
        .dataout(dout_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [2:0] got, input logic [2:0] exp);
        vectors_applied++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: dataout/busy/done got %b, expected %b", name, $time, got, exp);
        end
    endtask

    task automatic enq(input bit inst_b, input logic [2:0] e);
        if (inst_b) q_b.push_back(e);
        else        q_a.push_back(e);
    endtask

    // Reference stream: each copy sent MSB-first with busy high, gap zeros between copies,
    // then a lone done cycle and one idle cycle before the next start can be taken.
    task automatic push_expected(input bit inst_b, input logic [W-1:0] p, input int r);
        int gap;
        gap = inst_b ? GAP_B : GAP_A;
        for (int k = 0; k <= r; k++) begin
            for (int i = W - 1; i >= 0; i--) enq(inst_b, {p[i], 1'b1, 1'b0});
            if (k < r)
                for (int g = 0; g < gap; g++) enq(inst_b, 3'b010);
        end
        enq(inst_b, 3'b001);
        enq(inst_b, 3'b000);
    endtask

    task automatic wait_q_size(input bit inst_b, input int n);
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (((inst_b ? q_b.size() : q_a.size()) != n) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 2000) begin
            vectors_applied++;
            miscompares++;
            $display("[TB] FAIL wait_queue inst %0d: size %0d, required %0d",
                     inst_b, inst_b ? q_b.size() : q_a.size(), n);
            if (inst_b) q_b.delete();
            else        q_a.delete();
        end
    endtask

    task automatic apply_stimulus(input bit inst_b, input logic [W-1:0] p, input logic [RW-1:0] r);
        wait_q_size(inst_b, 0);
        pattern = p;
        reps    = r;
        if (inst_b) start_b = 1'b1;
        else        start_a = 1'b1;
        push_expected(inst_b, p, int'(r));
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        pattern = W'($urandom);
        reps    = RW'($urandom);
    endtask

    task automatic pulse_start(input bit inst_b);
        pattern = W'($urandom);
        reps    = RW'($urandom);
        if (inst_b) start_b = 1'b1;
        else        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #4;
        rst = 1'b0;
        q_a.delete();
        q_b.delete();
        #1;
        check_output("async_reset_a", {dout_a, busy_a, done_a}, 3'b000);
        check_output("async_reset_b", {dout_b, busy_b, done_b}, 3'b000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: one expected entry per cycle while a transfer is queued, idle otherwise.
    initial begin
        logic [2:0] exp_a, exp_b;
        forever begin
            @(posedge clk);
            #2;
            exp_a = 3'b000;
            exp_b = 3'b000;
            if (q_a.size() > 0) exp_a = q_a.pop_front();
            if (q_b.size() > 0) exp_b = q_b.pop_front();
            check_output("mon_a", {dout_a, busy_a, done_a}, exp_a);
            check_output("mon_b", {dout_b, busy_b, done_b}, exp_b);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst     = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        pattern = '0;
        reps    = '0;
        #1;
        check_output("power_on_reset_a", {dout_a, busy_a, done_a}, 3'b000);
        check_output("power_on_reset_b", {dout_b, busy_b, done_b}, 3'b000);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        $display("[TB] single transfer 8'hB4");
        apply_stimulus(1'b0, 8'hB4, 4'd0);

        $display("[TB] repeat with gap 8'h81 x3, ignored starts in SHIFT and DONE");
        apply_stimulus(1'b0, 8'h81, 4'd2);
        repeat (5) @(negedge clk);
        pulse_start(1'b0);
        wait_q_size(1'b0, 1);
        pulse_start(1'b0);

        $display("[TB] back-to-back 8'hFF x2 on GAP=0 instance");
        apply_stimulus(1'b1, 8'hFF, 4'd1);

        $display("[TB] maximum repeat count");
        apply_stimulus(1'b0, 8'hA5, 4'd15);

        $display("[TB] abort by reset mid-transfer, then clean restart");
        apply_stimulus(1'b0, 8'hC3, 4'd1);
        repeat (3) @(negedge clk);
        apply_reset();
        apply_stimulus(1'b0, 8'h0F, 4'd0);

        $display("[TB] randomized transfers");
        for (int n = 0; n < 12; n++) begin
            apply_stimulus(1'($urandom), W'($urandom), RW'($urandom_range(0, 3)));
        end

        wait_q_size(1'b0, 0);
        wait_q_size(1'b1, 0);
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
